// File: rtl/ram_cmd_master.sv
// Command initiator for the 1024x8 level-strobed RAM: single read/write, block fill and
// forward block copy, with all strobes and status registered.
module ram_cmd_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_out
);

  // state     | meaning
  // IDLE      | waiting for a command, cmd_ready high
  // WR        | single write strobe
  // RD_REQ    | single read strobe
  // RD_CAP    | RAM output captured into rsp_data
  // FILL      | one write strobe per byte
  // CPY_RD    | copy: read strobe at source
  // CPY_CAP   | copy: source byte captured
  // CPY_WR    | copy: write strobe at destination
  // FIN       | done (and err) pulse
  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_RD_REQ, S_RD_CAP, S_FILL, S_CPY_RD, S_CPY_CAP, S_CPY_WR, S_FIN
  } state_t;

  localparam logic [1:0]      OP_WRITE = 2'd0;
  localparam logic [1:0]      OP_READ  = 2'd1;
  localparam logic [1:0]      OP_FILL  = 2'd2;
  localparam logic [1:0]      OP_COPY  = 2'd3;
  localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [ADDR_W:0]   r_cnt;
  logic              w_accept, w_len_ok, w_last;
  logic              w_wr, w_rd, w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;

  assign w_accept = (r_state == S_IDLE) && cmd_valid && cmd_ready;
  assign w_len_ok = (cmd_len != '0) && (cmd_len <= MAX_LEN);
  assign w_last   = (r_cnt == (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Strobe values are decided for the state being entered, so they are registered
  // and line up exactly with that state's cycle.
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    w_err  = 1'b0;
    w_addr = mem_address;
    w_din  = mem_datain;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_WRITE: begin
              w_next = S_WR;
              w_wr   = 1'b1;
              w_addr = cmd_addr;
              w_din  = cmd_data;
            end
            OP_READ: begin
              w_next = S_RD_REQ;
              w_rd   = 1'b1;
              w_addr = cmd_addr;
            end
            OP_FILL: begin
              if (w_len_ok) begin
                w_next = S_FILL;
                w_wr   = 1'b1;
                w_addr = cmd_addr;
                w_din  = cmd_data;
              end else begin
                w_next = S_FIN;
                w_err  = 1'b1;
              end
            end
            default: begin
              if (w_len_ok) begin
                w_next = S_CPY_RD;
                w_rd   = 1'b1;
                w_addr = cmd_src;
              end else begin
                w_next = S_FIN;
                w_err  = 1'b1;
              end
            end
          endcase
        end
      end
      S_WR:     w_next = S_FIN;
      S_RD_REQ: w_next = S_RD_CAP;
      S_RD_CAP: w_next = S_FIN;
      S_FILL: begin
        if (w_last) begin
          w_next = S_FIN;
        end else begin
          w_wr   = 1'b1;
          w_addr = r_dst + ADDR_W'(1);
        end
      end
      S_CPY_RD: w_next = S_CPY_CAP;
      S_CPY_CAP: begin
        // mem_datain itself holds the copied byte through the write cycle
        w_next = S_CPY_WR;
        w_wr   = 1'b1;
        w_addr = r_dst;
        w_din  = mem_out;
      end
      S_CPY_WR: begin
        if (w_last) begin
          w_next = S_FIN;
        end else begin
          w_next = S_CPY_RD;
          w_rd   = 1'b1;
          w_addr = r_src + ADDR_W'(1);
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src <= cmd_src;
            r_dst <= cmd_addr;
            r_cnt <= cmd_len;
          end
        end
        S_FILL, S_CPY_WR: begin
          r_src <= r_src + ADDR_W'(1);
          r_dst <= r_dst + ADDR_W'(1);
          r_cnt <= r_cnt - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_address <= '0;
      mem_datain  <= '0;
    end else begin
      cmd_ready   <= (w_next == S_IDLE);
      busy        <= (w_next != S_IDLE);
      done        <= (w_next == S_FIN);
      err         <= w_err;
      rsp_valid   <= (r_state == S_RD_CAP);
      mem_wr      <= w_wr;
      mem_rd      <= w_rd;
      mem_address <= w_addr;
      mem_datain  <= w_din;
      if (r_state == S_RD_CAP) rsp_data <= mem_out;
    end
  end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Scoreboard bench for ram_cmd_master: a behavioural RAM, an array reference model and
// a negedge monitor that checks every strobe and every completion against queued expectations.
module tb_ram_cmd_master;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          done, err, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain;
  logic          mem_wr, mem_rd;
  logic [DW-1:0] mem_out = '0;

  always #5 clk = ~clk;

  ram_cmd_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_src(cmd_src), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err), .busy(busy),
    .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_out(mem_out)
  );

  // behavioural 1024x8 RAM: write on wr, registered output on rd
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_address] <= mem_datain;
    if (mem_rd) mem_out <= ram[mem_address];
  end

  logic [DW-1:0] mdl [1024];

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            off;
  } acc_t;

  typedef struct {
    logic          exp_err;
    logic          is_rd;
    logic [DW-1:0] data;
    int            lat;
    int            nacc;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int t_acc = 0;
  int last_done = 0;
  int n_strobe = 0;
  int proto = 0;
  logic [DW-1:0] last_rsp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  always @(negedge clk) begin : mon
    acc_t a;
    rsp_t r;
    ncyc++;
    if (rst) begin
      acc_q.delete();
      rsp_q.delete();
      last_rsp = '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        t_acc    = ncyc;
        n_strobe = 0;
      end
      if (mem_wr && mem_rd) proto++;
      if (busy && cmd_ready) proto++;
      if ((mem_wr || mem_rd) && !busy) proto++;
      if ((rsp_valid || err) && !done) proto++;
      if (mem_wr || mem_rd) begin
        n_strobe++;
        if (acc_q.size() == 0) begin
          chk("unexpected strobe", {22'd0, mem_address}, 32'hFFFF_FFFF);
        end else begin
          a = acc_q.pop_front();
          chk("strobe kind wr", {31'd0, mem_wr}, {31'd0, a.is_wr});
          chk("strobe addr", {22'd0, mem_address}, {22'd0, a.addr});
          if (a.is_wr) chk("strobe datain", {24'd0, mem_datain}, {24'd0, a.data});
          chk("strobe cycle offset", ncyc - t_acc, a.off);
        end
      end
      if (done) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected done", 32'd1, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          chk("done latency", ncyc - t_acc, r.lat);
          chk("err flag", {31'd0, err}, {31'd0, r.exp_err});
          chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, r.is_rd});
          if (r.is_rd) last_rsp = r.data;
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, last_rsp});
          chk("strobe count", n_strobe, r.nacc);
          last_done = ncyc;
        end
      end
    end
  end

  // Reference semantics: apply the command to mdl and queue the strobes it implies.
  task automatic expect_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [AW-1:0] src, input logic [AW:0] len,
                            input logic [DW-1:0] data);
    rsp_t r;
    logic [AW-1:0] s, d;
    logic [DW-1:0] b;
    int n;
    n = int'(len);
    r.exp_err = 1'b0;
    r.is_rd   = 1'b0;
    r.data    = '0;
    if (op >= 2'd2 && (n == 0 || n > 1024)) begin
      r.exp_err = 1'b1;
      r.lat     = 1;
      r.nacc    = 0;
    end else begin
      case (op)
        2'd0: begin
          mdl[addr] = data;
          acc_q.push_back('{1'b1, addr, data, 1});
          r.lat = 2; r.nacc = 1;
        end
        2'd1: begin
          r.is_rd = 1'b1;
          r.data  = mdl[addr];
          acc_q.push_back('{1'b0, addr, '0, 1});
          r.lat = 3; r.nacc = 1;
        end
        2'd2: begin
          for (int i = 0; i < n; i++) begin
            d = addr + AW'(i);
            mdl[d] = data;
            acc_q.push_back('{1'b1, d, data, 1 + i});
          end
          r.lat = n + 1; r.nacc = n;
        end
        default: begin
          for (int i = 0; i < n; i++) begin
            s = src + AW'(i);
            d = addr + AW'(i);
            b = mdl[s];
            acc_q.push_back('{1'b0, s, '0, 1 + 3*i});
            mdl[d] = b;
            acc_q.push_back('{1'b1, d, b, 3 + 3*i});
          end
          r.lat = 3*n + 1; r.nacc = 2*n;
        end
      endcase
    end
    rsp_q.push_back(r);
  endtask

  task automatic wait_ready(input string who);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 5000);
    if (!cmd_ready) begin
      chk({"timeout waiting ready: ", who}, 32'd0, 32'd1);
      finish_run();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [AW-1:0] src, input logic [AW:0] len,
                       input logic [DW-1:0] data);
    wait_ready("issue");
    @(posedge clk); #1;
    expect_cmd(op, addr, src, len, data);
    cmd_op = op; cmd_addr = addr; cmd_src = src; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (rsp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() != 0) chk("timeout waiting done", rsp_q.size(), 32'd0);
  endtask

  initial begin
    int bad;
    int k;
    logic [AW:0] ln;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = DW'($urandom);
      mdl[i] = ram[i];
    end

    @(posedge clk); @(negedge clk);
    chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
    chk("reset mem_address", {22'd0, mem_address}, 32'd0);
    chk("reset mem_datain", {24'd0, mem_datain}, 32'd0);
    chk("reset rsp_data", {24'd0, rsp_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // write then read back
    issue(2'd0, 10'h005, '0, '0, 8'h3A);
    issue(2'd1, 10'h005, '0, '0, 8'h00);

    // fill across the top-of-memory wrap
    issue(2'd2, 10'h3FE, '0, 11'd4, 8'h55);
    for (int i = 0; i < 4; i++) issue(2'd1, 10'h3FE + AW'(i), '0, '0, 8'h00);

    // copy
    issue(2'd0, 10'h010, '0, '0, 8'h11);
    issue(2'd0, 10'h011, '0, '0, 8'h22);
    issue(2'd0, 10'h012, '0, '0, 8'h33);
    issue(2'd3, 10'h200, 10'h010, 11'd3, 8'h00);
    for (int i = 0; i < 3; i++) issue(2'd1, 10'h200 + AW'(i), '0, '0, 8'h00);

    // illegal lengths
    issue(2'd2, 10'h050, '0, 11'd0, 8'hEE);
    issue(2'd3, 10'h060, 10'h000, 11'd1025, 8'h00);
    issue(2'd1, 10'h050, '0, '0, 8'h00);
    issue(2'd1, 10'h060, '0, '0, 8'h00);

    // overlapping forward copy
    issue(2'd3, 10'h012, 10'h010, 11'd4, 8'h00);

    // command held valid while a fill is busy
    issue(2'd2, 10'h040, '0, 11'd8, 8'h77);
    expect_cmd(2'd0, 10'h047, '0, '0, 8'hE1);
    cmd_op = 2'd0; cmd_addr = 10'h047; cmd_len = '0; cmd_data = 8'hE1;
    cmd_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 100);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("held cmd accepted cycle after FIN", t_acc, last_done + 1);
    issue(2'd1, 10'h047, '0, '0, 8'h00);
    issue(2'd1, 10'h046, '0, '0, 8'h00);

    // reset in the 3rd fill cycle
    issue(2'd0, 10'h103, '0, '0, 8'h5C);
    wait_ready("reset test");
    @(posedge clk); #1;
    cmd_op = 2'd2; cmd_addr = 10'h100; cmd_len = 11'd8; cmd_data = 8'hAA;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) mdl[10'h100 + AW'(i)] = 8'hAA;
    acc_q.push_back('{1'b1, 10'h100, 8'hAA, 1});
    acc_q.push_back('{1'b1, 10'h101, 8'hAA, 2});
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("strobes after reset edge", {30'd0, mem_wr, mem_rd}, 32'd0);
    chk("done after reset edge", {31'd0, done}, 32'd0);
    chk("busy after reset edge", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cmd_ready after reset", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) issue(2'd1, 10'h100 + AW'(i), '0, '0, 8'h00);

    // maximum legal length
    issue(2'd2, 10'h3F8, '0, 11'd1024, 8'hC3);
    issue(2'd1, 10'h3F7, '0, '0, 8'h00);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0) ln = ($urandom_range(0, 1) == 0) ? 11'd0 : 11'(1025 + $urandom_range(0, 1022));
      else        ln = 11'($urandom_range(1, 12));
      issue(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom), ln, DW'($urandom));
    end

    drain();
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== mdl[i]) bad++;
    chk("final RAM image mismatches", bad, 32'd0);
    chk("protocol violations", proto, 32'd0);
    finish_run();
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    errors++;
    finish_run();
  end

endmodule

// File: doc/ram_cmd_master.md
Name: ram_cmd_master

Overview:
- Command-driven initiator for the 1024x8 RAM macro (level-sensitive `address` / `datain` / `wr` / `rd` / `out` interface).
- Accepts single-byte read/write, block fill and block copy commands over a valid/ready handshake.
- Sequences the RAM strobes to complete each command and returns read data and completion status.
- Sits between the system controller and the RAM instance, so the RAM is never driven directly by logic that lacks strobe sequencing.

Parameters:
- ADDR_W, 10, RAM address width (1024 locations).
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_op  input  2  0=WRITE, 1=READ, 2=FILL, 3=COPY.
- cmd_addr  input  ADDR_W  target/destination start address.
- cmd_src  input  ADDR_W  COPY source start address (ignored otherwise).
- cmd_len  input  ADDR_W+1  byte count for FILL/COPY, legal range 1..1024.
- cmd_data  input  DATA_W  WRITE data / FILL value.
- rsp_valid  output  1  one-cycle pulse, rsp_data valid (READ only).
- rsp_data  output  DATA_W  read result; holds value until next READ.
- done  output  1  one-cycle pulse at command completion (also on error).
- err  output  1  one-cycle pulse with done for an illegal command.
- busy  output  1  high from acceptance until the done cycle inclusive.
- mem_address  output  ADDR_W  to RAM `address`.
- mem_datain  output  DATA_W  to RAM `datain`.
- mem_wr  output  1  to RAM `wr`.
- mem_rd  output  1  to RAM `rd`.
- mem_out  input  DATA_W  from RAM `out`.

Behaviour:
- All outputs are registered.
- Reset values:
  - cmd_ready=0 in the reset cycle, then 1 (IDLE).
  - All other outputs 0: rsp_data=0x00, mem_address=0, mem_datain=0, mem_wr=0, mem_rd=0.
- Handshake:
  - Accept on a rising edge with cmd_valid&&cmd_ready (cycle T). All command fields are captured at that edge.
  - cmd_valid while busy is ignored, not queued.
- Strobe rules:
  - mem_wr and mem_rd are never high together.
  - Each strobe is high for exactly one cycle per access.
  - mem_address/mem_datain are stable for the whole strobe cycle.
  - Strobes are 0 in every non-access cycle.
- States: IDLE, WR, RD_REQ, RD_CAP, FILL, CPY_RD, CPY_CAP, CPY_WR, FIN.
  - WRITE: IDLE -> WR (cycle T+1, mem_wr=1, addr=cmd_addr, datain=cmd_data) -> FIN (T+2: done=1) -> IDLE.
  - READ: IDLE -> RD_REQ (T+1, mem_rd=1) -> RD_CAP (T+2, strobes 0, mem_out sampled into rsp_data at end of cycle) -> FIN (T+3: rsp_valid=1, done=1) -> IDLE.
  - FILL: IDLE -> FILL for cmd_len cycles.
    - Each FILL cycle: mem_wr=1, mem_datain=fill value, address incrementing by 1 from cmd_addr.
    - Then FIN (done=1). Latency: len+1 cycles after acceptance to done.
  - COPY: per byte, CPY_RD (mem_rd=1 at src) -> CPY_CAP (sample mem_out into internal byte register) -> CPY_WR (mem_wr=1 at dst, datain=byte).
    - src and dst each increment after every byte; repeat cmd_len times, then FIN.
    - Latency: 3*len+1 cycles to done.
- Address arithmetic: modulo 2^ADDR_W. An address of 1023 increments to 0 with no error.
- Internal remaining-count register is ADDR_W+1 bits and decrements per byte; the last byte is taken when count reaches 1.
- Overlapping COPY: strictly forward, byte-sequential (read byte i, then write byte i). Result when dst is in (src, src+len) is defined by that ordering; no special handling.
- Illegal commands: cmd_len=0 or cmd_len>1024 on FILL/COPY.
  - No memory access is performed.
  - IDLE -> FIN at T+1 with done=1 and err=1.
  - WRITE/READ ignore cmd_len.
- busy is high from T+1 through the FIN cycle; cmd_ready is low over the same span. The next command can be accepted at the edge ending the cycle after FIN.
- Reset mid-operation: at the reset edge the state returns to IDLE and all strobes drop to 0. The in-flight command is abandoned; no done is pulsed.
- rsp_data is unchanged by WRITE/FILL/COPY.

Test Plan:
- WRITE addr=0x005 data=0x3A, then READ addr=0x005:
  - mem_wr high exactly 1 cycle at T+1 with address 0x005.
  - READ rsp_valid and done both pulse at T+3 with rsp_data=0x3A.
- FILL addr=0x3FE len=4 data=0x55:
  - mem_wr high 4 consecutive cycles at addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - done at T+5; READs of all four return 0x55.
- Setup and COPY:
  - Setup: preload 0x010..0x012 = 0x11, 0x22, 0x33.
  - Stimulus: COPY src=0x010 dst=0x200 len=3.
  - Required response: rd/cap/wr pattern repeats 3 times; done at T+10; READ 0x200..0x202 returns 0x11, 0x22, 0x33.
- FILL len=0 and COPY len=1025:
  - done and err pulse together at T+1.
  - mem_wr and mem_rd stay 0 throughout.
  - RAM contents unchanged.
- cmd_valid held high with a second WRITE while a FILL len=8 is busy:
  - cmd_ready stays 0 and the second command is not executed until re-presented after FIN.
- Assert rst during the 3rd cycle of FILL addr=0x100 len=8 data=0xAA:
  - Strobes drop to 0 on the reset edge and no done pulse is seen.
  - Only 0x100..0x102 hold 0xAA; 0x103 is untouched.
  - cmd_ready=1 on the cycle after reset deasserts.
